buffer_uart_tx: RTL and testbench

- Drain side of the system circular buffer. Pops words through the buffer read port (rd strobe, registered data_out, buffer_empty) and transmits each word as a UART 8N1-style frame on tx.
- Sits between the command/data buffer and the board UART pin. It is the transmit counterpart to buffer writers fed by receivers or host logic.

---
 rtl/uart_defs.sv | 18 +
 rtl/uart_baud_tick.sv | 29 ++
 rtl/buffer_uart_tx.sv | 119 +++++++++++
 tb/tb_buffer_uart_tx.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_defs.sv
// Shared state encodings and line-level constants for the buffer-drain UART transmitter.
package uart_defs;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LATCH = 3'd2,
        START = 3'd3,
        DATA  = 3'd4,
        STOP  = 3'd5
    } state_t;

    localparam int   NUM_OF_STATE = 6;
    localparam logic HIGH         = 1'b1;
    localparam logic LOW          = 1'b0;
    localparam logic TX_IDLE      = HIGH;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: tick is high in the last clk of every CLKS_PER_BIT-cycle bit period.
// clr holds the count at zero so the first period after release is full length.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic rstb,
    input  logic clr,
    output logic tick
);

    localparam int            CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] TERM = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_cnt <= '0;
        end else if (clr || tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign tick = !clr && (r_cnt == TERM);

endmodule

// File: rtl/buffer_uart_tx.sv
// Pops words from the circular buffer and sends each as an 8N1 frame on tx; start bit appears
// 3 clk after buf_rd. A started frame always completes; new words are fetched only when enabled.
module buffer_uart_tx
    import uart_defs::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic                  clk,
    input  logic                  rstb,
    input  logic                  enable,
    input  logic                  buf_empty,
    output logic                  buf_rd,
    input  logic [DATA_WIDTH-1:0] buf_data,
    output logic                  tx,
    output logic                  busy,
    output logic                  byte_done
);

    localparam int BW = $clog2(DATA_WIDTH) + 1;

    state_t                r_state;
    state_t                w_next;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] w_shift_nxt;
    logic [BW-1:0]         r_bit_cnt;
    logic                  r_tx;
    logic                  w_tx_nxt;
    logic                  w_tick;
    logic                  w_clr;
    logic                  w_fetch_ok;
    logic                  w_last_bit;

    assign w_fetch_ok = enable && !buf_empty;
    assign w_last_bit = (r_bit_cnt == BW'(DATA_WIDTH - 1));
    assign w_clr      = (r_state == IDLE) || (r_state == FETCH) || (r_state == LATCH);

    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .rstb (rstb),
        .clr  (w_clr),
        .tick (w_tick)
    );

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_fetch_ok) w_next = FETCH;
            FETCH:   w_next = LATCH;
            LATCH:   w_next = START;
            START:   if (w_tick) w_next = DATA;
            DATA:    if (w_tick && w_last_bit) w_next = STOP;
            STOP:    if (w_tick) w_next = w_fetch_ok ? FETCH : IDLE;
            default: w_next = IDLE;
        endcase
    end

    // The buffer advances its read pointer on any sampled rd, so rd must stay low while in reset.
    always_comb begin
        buf_rd    = LOW;
        byte_done = LOW;
        case (r_state)
            IDLE: buf_rd = w_fetch_ok && rstb;
            STOP: begin
                byte_done = w_tick;
                buf_rd    = w_tick && w_fetch_ok;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_shift_nxt = r_shift;
        if (r_state == LATCH) begin
            w_shift_nxt = buf_data;
        end else if ((r_state == DATA) && w_tick) begin
            w_shift_nxt = r_shift >> 1;
        end
    end

    // tx is registered from the next state so the line level changes on the state edge itself.
    always_comb begin
        case (w_next)
            START:   w_tx_nxt = LOW;
            DATA:    w_tx_nxt = w_shift_nxt[0];
            default: w_tx_nxt = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_tx      <= TX_IDLE;
        end else begin
            r_shift <= w_shift_nxt;
            r_tx    <= w_tx_nxt;
            if (r_state == LATCH) begin
                r_bit_cnt <= '0;
            end else if ((r_state == DATA) && w_tick) begin
                r_bit_cnt <= r_bit_cnt + BW'(1);
            end
        end
    end

    assign tx   = r_tx;
    assign busy = (r_state != IDLE);

endmodule

// File: tb/tb_buffer_uart_tx.sv
// Bench for buffer_uart_tx: buffer model, frame-timeline reference model, serial decoder, directed tests.
module tb_buffer_uart_tx;

    localparam int C         = 4;
    localparam int FRAME_END = 2 + 10 * C;  // rd cycle = 0, fetch = 1, latch = 2, frame = 3..42

    logic       clk;
    logic       rstb;
    logic       enable;
    logic       buf_empty;
    logic       buf_rd;
    logic [7:0] buf_data = 8'h00;
    logic       tx;
    logic       busy;
    logic       byte_done;

    buffer_uart_tx #(
        .DATA_WIDTH   (8),
        .CLKS_PER_BIT (C)
    ) dut (
        .clk       (clk),
        .rstb      (rstb),
        .enable    (enable),
        .buf_empty (buf_empty),
        .buf_rd    (buf_rd),
        .buf_data  (buf_data),
        .tx        (tx),
        .busy      (busy),
        .byte_done (byte_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Circular buffer model: data_out registered on the edge that samples rd; pointer always advances.
    logic [7:0] mem [0:15];
    int         rd_idx = 0;
    int         wr_cnt = 0;
    assign buf_empty = (rd_idx == wr_cnt);

    always @(posedge clk) begin
        if (buf_rd) begin
            buf_data <= mem[rd_idx];
            rd_idx   <= rd_idx + 1;
        end
    end

    // Reference model: position m_p within the fetch+frame timeline, -1 when idle.
    int         m_p = -1;
    logic [7:0] m_word = 8'h00;
    logic       e_tx, e_rd, e_busy, e_done;

    function automatic logic line_level(input int p, input logic [7:0] w);
        int k;
        if (p < 3) return 1'b1;
        k = (p - 3) / C;
        if (k == 0) return 1'b0;
        if (k <= 8) return w[k-1];
        return 1'b1;
    endfunction

    always @(negedge clk) begin
        if (!rstb) begin
            m_p = -1;
            e_tx = 1'b1; e_rd = 1'b0; e_busy = 1'b0; e_done = 1'b0;
        end else if (m_p < 0) begin
            e_tx = 1'b1; e_busy = 1'b0; e_done = 1'b0;
            e_rd = enable && !buf_empty;
        end else begin
            if (m_p == 2) m_word = buf_data;
            e_tx   = line_level(m_p, m_word);
            e_busy = 1'b1;
            e_done = (m_p == FRAME_END);
            e_rd   = e_done && enable && !buf_empty;
        end
        chk("model_tx", tx, e_tx);
        chk("model_buf_rd", buf_rd, e_rd);
        chk("model_busy", busy, e_busy);
        chk("model_byte_done", byte_done, e_done);
        if (!rstb)               m_p = -1;
        else if (e_rd)           m_p = 1;
        else if (m_p < 0)        m_p = -1;
        else if (m_p == FRAME_END) m_p = -1;
        else                     m_p = m_p + 1;
    end

    // Event recorder and serial decoder working only from the tx line.
    int         rd_q[$];
    int         fall_q[$];
    int         done_q[$];
    logic [9:0] frm_q[$];
    logic       prev_tx = 1'b1;
    bit         dec_on  = 1'b0;
    int         dec_t0  = 0;
    logic [9:0] dec_f   = '0;
    int         d;

    always @(negedge clk) begin
        cyc++;
        if (!rstb) begin
            dec_on = 1'b0;
        end else begin
            if (buf_rd)    rd_q.push_back(cyc);
            if (byte_done) done_q.push_back(cyc);
            if (prev_tx && !tx && !dec_on) begin
                dec_on = 1'b1;
                dec_t0 = cyc;
                fall_q.push_back(cyc);
            end
            if (dec_on) begin
                d = cyc - dec_t0;
                if ((d % C) == C / 2) begin
                    dec_f[d / C] = tx;
                    if (d / C == 9) begin
                        frm_q.push_back(dec_f);
                        dec_on = 1'b0;
                    end
                end
            end
        end
        prev_tx = tx;
    end

    task automatic wait_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_frames(input int n, input int budget);
        int t = 0;
        while (frm_q.size() < n && t < budget) begin
            wait_n(1);
            t++;
        end
        chk("frame_count_within_budget", frm_q.size(), n);
    endtask

    task automatic wait_fall_then(input int offs);
        int t = 0;
        while (fall_q.size() == 0 && t < 60) begin
            wait_n(1);
            t++;
        end
        chk("start_bit_seen", fall_q.size(), 1);
        if (fall_q.size() > 0) begin
            while (cyc < fall_q[0] + offs && t < 120) begin
                wait_n(1);
                t++;
            end
        end
    endtask

    task automatic clear_logs();
        rd_q.delete();
        fall_q.delete();
        done_q.delete();
        frm_q.delete();
    endtask

    logic [9:0] f;

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rstb   = 1'b0;
        enable = 1'b1;
        mem[0] = 8'hA5;
        wr_cnt = 1;

        // Reset held with data available and enable high
        repeat (5) begin
            @(negedge clk); #1;
            chk("rst_tx", tx, 1);
            chk("rst_buf_rd", buf_rd, 0);
            chk("rst_busy", busy, 0);
            chk("rst_byte_done", byte_done, 0);
        end
        @(posedge clk); #1;
        rstb = 1'b1;
        @(negedge clk); #1;
        chk("rd_first_clk_after_reset", buf_rd, 1);

        // Single word 0xA5
        wait_frames(1, 80);
        wait_n(8);
        if (frm_q.size() >= 1) chk("a5_bits", frm_q[0], 10'b1101001010);
        if (rd_q.size() >= 1 && fall_q.size() >= 1) chk("a5_rd_to_fall", fall_q[0] - rd_q[0], 3);
        if (done_q.size() >= 1 && fall_q.size() >= 1) chk("a5_fall_to_done", done_q[0] - fall_q[0], 39);
        chk("a5_done_count", done_q.size(), 1);
        chk("a5_idle_after", busy, 0);

        // Back-to-back 0x01, 0x80, 0xFF
        clear_logs();
        mem[1] = 8'h01; mem[2] = 8'h80; mem[3] = 8'hFF;
        wr_cnt = 4;
        wait_frames(3, 200);
        wait_n(8);
        chk("b2b_rd_count", rd_q.size(), 3);
        chk("b2b_done_count", done_q.size(), 3);
        if (frm_q.size() == 3) begin
            f = frm_q[0]; chk("b2b_byte0", {f[9], f[8:1], f[0]}, {1'b1, 8'h01, 1'b0});
            f = frm_q[1]; chk("b2b_byte1", {f[9], f[8:1], f[0]}, {1'b1, 8'h80, 1'b0});
            f = frm_q[2]; chk("b2b_byte2", {f[9], f[8:1], f[0]}, {1'b1, 8'hFF, 1'b0});
        end
        // Start-to-start spacing = 40-clk frame + fetch + latch, i.e. a 4+2 clk high gap
        if (fall_q.size() == 3) begin
            chk("b2b_spacing01", fall_q[1] - fall_q[0], 42);
            chk("b2b_spacing12", fall_q[2] - fall_q[1], 42);
        end

        // Empty guard
        clear_logs();
        wait_n(100);
        chk("empty_rd_count", rd_q.size(), 0);
        chk("empty_tx", tx, 1);
        chk("empty_busy", busy, 0);

        // enable dropped during data bit 3 of 0x3C with another word waiting
        clear_logs();
        mem[4] = 8'h3C; mem[5] = 8'h55;
        wr_cnt = 6;
        wait_fall_then(4 * C + 1);
        enable = 1'b0;
        wait_frames(1, 60);
        wait_n(20);
        if (frm_q.size() >= 1) chk("en_drop_frame", frm_q[0], {1'b1, 8'h3C, 1'b0});
        chk("en_drop_done_count", done_q.size(), 1);
        chk("en_drop_rd_count", rd_q.size(), 1);
        chk("en_drop_idle", busy, 0);
        enable = 1'b1;
        wait_frames(2, 80);
        wait_n(8);
        if (frm_q.size() >= 2) chk("en_resume_frame", frm_q[1], {1'b1, 8'h55, 1'b0});

        // Reset during data bit 5 of 0x96; next word 0x6B must go out intact
        clear_logs();
        mem[6] = 8'h96; mem[7] = 8'h6B;
        wr_cnt = 8;
        wait_fall_then(6 * C + 1);
        chk("pre_reset_tx_low_bit5", tx, 0);
        rstb = 1'b0;
        #1;
        chk("async_reset_tx", tx, 1);
        chk("async_reset_busy", busy, 0);
        wait_n(2);
        rstb = 1'b1;
        wait_frames(1, 100);
        wait_n(8);
        if (frm_q.size() >= 1) chk("post_reset_frame", frm_q[0], {1'b1, 8'h6B, 1'b0});
        chk("post_reset_rd_count", rd_q.size(), 2);
        chk("post_reset_done_count", done_q.size(), 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
